// File: rtl/pwm_audio_dac.sv
// PWM audio DAC: qualifies the synchronised sample for stability, latches it only at
// period boundaries and plays it as a single-bit PWM stream of period 2^WIDTH.
module pwm_audio_dac #(
    parameter int WIDTH         = 12,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             slow_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sync_data,
    input  logic             enable,
    output logic             pwm_out,
    output logic             period_start,
    output logic [WIDTH-1:0] active_sample,
    output logic             sample_changed
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [2:0]       STABLE_N = 3'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        MUTE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] candidate_r;
    logic [2:0]       run_len_r;
    logic [2:0]       run_len_nxt_s;
    logic             cand_load_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             pwm_r;
    logic             pwm_nxt_s;
    logic             period_start_r;
    logic             period_start_nxt_s;
    logic [WIDTH-1:0] active_sample_r;
    logic [WIDTH-1:0] active_sample_nxt_s;
    logic             sample_changed_r;
    logic             sample_changed_nxt_s;
    logic             period_end_s;

    // Run-length of the current sync_data value, saturating at STABLE_CYCLES.
    always_comb begin
        run_len_nxt_s = 3'd1;
        if (sync_data == prev_r) begin
            if (run_len_r >= STABLE_N) begin
                run_len_nxt_s = STABLE_N;
            end else begin
                run_len_nxt_s = run_len_r + 3'd1;
            end
        end else begin
            run_len_nxt_s = 3'd1;
        end
        cand_load_s = (run_len_nxt_s == STABLE_N);
    end

    // Stability filter registers; candidate only takes values held long enough.
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r      <= '0;
            run_len_r   <= 3'd0;
            candidate_r <= '0;
        end else begin
            prev_r    <= sync_data;
            run_len_r <= run_len_nxt_s;
            if (cand_load_s) begin
                candidate_r <= sync_data;
            end else begin
                candidate_r <= candidate_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= MUTE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: enable alone moves between MUTE and RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MUTE: begin
                if (enable) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = MUTE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt_s = MUTE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = MUTE;
        endcase
    end

    // FSM output logic: next values of counter and registered outputs.
    always_comb begin
        cnt_nxt_s            = '0;
        pwm_nxt_s            = 1'b0;
        period_start_nxt_s   = 1'b0;
        active_sample_nxt_s  = active_sample_r;
        sample_changed_nxt_s = 1'b0;
        period_end_s         = (cnt_r == CNT_MAX);
        case (state_r)
            MUTE: begin
                if (enable) begin
                    active_sample_nxt_s  = candidate_r;
                    period_start_nxt_s   = 1'b1;
                    sample_changed_nxt_s = (candidate_r != active_sample_r);
                end else begin
                    period_start_nxt_s = 1'b0;
                end
            end
            RUN: begin
                if (!enable) begin
                    cnt_nxt_s = '0;
                end else begin
                    cnt_nxt_s          = cnt_r + WIDTH'(1);
                    pwm_nxt_s          = (cnt_r < active_sample_r);
                    period_start_nxt_s = period_end_s;
                    // The candidate registered before this edge is the one that gets loaded.
                    if (period_end_s) begin
                        active_sample_nxt_s  = candidate_r;
                        sample_changed_nxt_s = (candidate_r != active_sample_r);
                    end else begin
                        sample_changed_nxt_s = 1'b0;
                    end
                end
            end
            default: begin
                cnt_nxt_s = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r            <= '0;
            pwm_r            <= 1'b0;
            period_start_r   <= 1'b0;
            active_sample_r  <= '0;
            sample_changed_r <= 1'b0;
        end else begin
            cnt_r            <= cnt_nxt_s;
            pwm_r            <= pwm_nxt_s;
            period_start_r   <= period_start_nxt_s;
            active_sample_r  <= active_sample_nxt_s;
            sample_changed_r <= sample_changed_nxt_s;
        end
    end

    assign pwm_out        = pwm_r;
    assign period_start   = period_start_r;
    assign active_sample  = active_sample_r;
    assign sample_changed = sample_changed_r;

endmodule

// File: doc/pwm_audio_dac.md
Name: pwm_audio_dac

Overview:
- Consumes the 12-bit audio sample delivered into the slow clock domain by the fast-to-slow synchroniser.
- Qualifies the sample for stability and latches it only at PWM period boundaries.
- Drives a single-bit PWM audio output whose duty cycle equals sample / 2^WIDTH.
- Sits between the clock-domain crossing and the board audio pin. It is the last stage of the audio path.

Parameters:
- WIDTH, 12, sample width and PWM counter width; period = 2^WIDTH slow_clk cycles.
- STABLE_CYCLES, 2, number of consecutive slow_clk edges sync_data must hold one value before it is accepted (legal range 1..7).

Ports:
- slow_clk  input  1  single clock for the whole block.
- reset_n  input  1  asynchronous, active-low reset.
- sync_data  input  WIDTH  unsigned sample from the synchroniser.
- enable  input  1  1 = play, 0 = mute.
- pwm_out  output  1  registered PWM audio output.
- period_start  output  1  one-cycle pulse in the first cycle of each PWM period.
- active_sample  output  WIDTH  sample currently being played.
- sample_changed  output  1  one-cycle pulse, coincident with period_start, when the newly loaded sample differs from the previous one.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pwm_out, period_start, sample_changed = 0.
  - active_sample, candidate, prev, run_len, cnt = 0.
  - state = MUTE.
  - Reset asserted mid-period forces all outputs to 0 immediately, without waiting for a clock edge.
- Stability filter (runs every cycle, in both states):
  - prev <= sync_data.
  - If sync_data == prev, run_len <= min(run_len+1, STABLE_CYCLES); otherwise run_len <= 1.
  - candidate <= sync_data at the edge where the updated run_len first reaches STABLE_CYCLES.
  - Values held for fewer edges never reach candidate.
  - If STABLE_CYCLES = 1, candidate follows sync_data every cycle.
- FSM states: MUTE, RUN.
- MUTE:
  - cnt = 0, pwm_out = 0, period_start = 0, sample_changed = 0; active_sample holds its value.
  - On an edge with enable=1: state <= RUN, cnt <= 0, active_sample <= candidate, period_start <= 1.
  - On that same edge, sample_changed <= (candidate != active_sample).
- RUN, each edge:
  - cnt <= cnt+1, wrapping from 2^WIDTH-1 to 0.
  - pwm_out <= (cnt < active_sample), unsigned comparison. pwm_out therefore lags cnt by one cycle.
  - period_start <= (cnt == 2^WIDTH-1).
  - When cnt == 2^WIDTH-1: active_sample <= candidate and sample_changed <= (candidate != active_sample). Otherwise sample_changed <= 0.
- RUN, enable=0 at an edge (takes priority):
  - state <= MUTE, cnt <= 0, pwm_out <= 0, period_start <= 0, sample_changed <= 0.
  - Muting is immediate and never waits for the period to end.
- Duty: in steady state, pwm_out is high for exactly active_sample cycles per 2^WIDTH-cycle period.
  - active_sample = 0 gives a constant low output.
  - active_sample = 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles.
- Simultaneous candidate update and period boundary on the same edge: active_sample takes the candidate value registered before that edge. The new value plays from the following period.
- active_sample changes only at period boundaries or on MUTE->RUN entry. It never changes mid-period.

Test Plan:
- Reset, then enable=0 and sync_data=0x800 held for 10000 cycles -> pwm_out=0, period_start=0, active_sample=0 throughout.
- enable=1, sync_data=0x800 stable -> period_start pulses every 4096 cycles; pwm_out high for exactly 2048 cycles per period; sample_changed pulses once, on the first load only.
- Stable sync_data=0x000, then 0xFFF -> 0x000 gives 0 high cycles per period; 0xFFF gives 4095 high and 1 low per period.
- sync_data 0x400 with a single-cycle glitch to 0x100 -> candidate and active_sample never equal 0x100; duty stays 1024/4096.
- sync_data steps 0x400 -> 0xC00 at cnt=1000 -> current period has 1024 high cycles; next period has 3072; sample_changed pulses once, together with that period's period_start.
- Drop enable at cnt=500 -> pwm_out=0 from the next cycle, no period_start. Re-raise enable -> period_start one cycle later, with a fresh 4096-cycle period. Assert reset_n=0 mid-RUN -> all outputs 0 immediately.
